// File: rtl/mm2s_pkg.sv
// mm2s_pkg: shared types and field positions for the multi-destination MM2S controller
package mm2s_pkg;
  localparam int ADDR_W = 32;
  localparam int BTT_W  = 23;
  localparam int DEST_W = 2;
  localparam int TAG_W  = 4;
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DEST_W-1:0] dest;
    logic [BTT_W-1:0]  btt;
    logic [ADDR_W-1:0] addr;
  } mm2s_instr_t;
  localparam int MM2S_INSTR_W = $bits(mm2s_instr_t);
  localparam int CMD_TYPE_BIT = 23;
  localparam int CMD_EOF_BIT  = 30;
  localparam int CMD_ADDR_LSB = 32;
  localparam int STS_OKAY_BIT = 7;
  localparam int STS_TAG_LSB  = 0;
  localparam int STS_TAG_W    = 4;
  localparam int ST2_ERR_STS  = 8;
  localparam int ST2_ERR_LAST = 9;
  localparam int ST2_ERR_ZERO = 10;
  typedef enum logic {ST_IDLE, ST_ISSUE} mm2s_state_t;
endpackage

// File: rtl/fifo_axis.sv
// fifo_axis: synchronous AXI-stream FIFO with active-low synchronous reset
module fifo_axis #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             s_tready,
  input  logic             s_tvalid,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             m_tready,
  output logic             m_tvalid,
  output logic [WIDTH-1:0] m_tdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic push, pop;
  assign s_tready = rst_n & (cnt != CW'(DEPTH));
  assign m_tvalid = cnt != '0;
  assign m_tdata  = mem[rp];
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  // circular buffer pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= s_tdata;
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/mm2s_mc_route.sv
// mm2s_mc_route: tag queue plus beat counter steering read data to its destination
module mm2s_mc_route #(
  parameter int DATA_W = 128,
  parameter int DEST_W = 2,
  parameter int DEPTH  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [DEST_W-1:0]   push_dest,
  input  logic [22:0]         push_beats,
  output logic                full,
  output logic                s_tready,
  input  logic                s_tvalid,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tlast,
  input  logic                m_tready,
  output logic                m_tvalid,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tlast,
  output logic [DEST_W-1:0]   m_tdest,
  output logic                err_last
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DEST_W+22:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [22:0] bcnt, hd_beats;
  logic nonempty, hs, pop;
  assign nonempty = cnt != '0;
  assign full     = cnt == CW'(DEPTH);
  assign hd_beats = mem[rp][22:0];
  assign m_tdest  = mem[rp][DEST_W+22:23];
  assign s_tready = m_tready & nonempty;
  assign m_tvalid = s_tvalid & nonempty;
  assign m_tdata  = s_tdata;
  assign m_tkeep  = s_tkeep;
  assign m_tlast  = bcnt == hd_beats - 23'd1;
  assign hs       = s_tvalid & s_tready;
  assign pop      = hs & m_tlast;
  assign err_last = hs & (s_tlast != m_tlast);
  // tag queue and per-transfer beat count; a tag pushed now is routable next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wp   <= '0;
      rp   <= '0;
      cnt  <= '0;
      bcnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= {push_dest, push_beats};
        wp      <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      cnt  <= cnt + CW'(push) - CW'(pop);
      bcnt <= pop ? 23'd0 : hs ? bcnt + 23'd1 : bcnt;
    end
  end
endmodule

// File: rtl/mm2s_mc_ctrl.sv
// mm2s_mc_ctrl: credit-limited MM2S command issue and routed read data; MM2S_PERF_CNT_EN adds perf counters
module mm2s_mc_ctrl
  import mm2s_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH   = 32,
  parameter int AXI_DATA_WIDTH   = 128,
  parameter int NUM_DEST         = 4,
  parameter int INSTR_FIFO_DEPTH = 128,
  parameter int MAX_OUTSTANDING  = 8,
  localparam int DEST_WIDTH      = NUM_DEST > 1 ? $clog2(NUM_DEST) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   scalar,
  output logic [2:0][31:0]              status,
  output logic                          s_axis_mm2s_instr_tready,
  input  logic                          s_axis_mm2s_instr_tvalid,
  input  logic [MM2S_INSTR_W-1:0]       s_axis_mm2s_instr_tdata,
  input  logic                          m_axis_mm2s_cmd_tready,
  output logic                          m_axis_mm2s_cmd_tvalid,
  output logic [AXI_ADDR_WIDTH+39:0]    m_axis_mm2s_cmd_tdata,
  output logic                          s_axis_mm2s_sts_tready,
  input  logic                          s_axis_mm2s_sts_tvalid,
  input  logic [7:0]                    s_axis_mm2s_sts_tdata,
  output logic                          s_axis_mm2s_tready,
  input  logic                          s_axis_mm2s_tvalid,
  input  logic [AXI_DATA_WIDTH-1:0]     s_axis_mm2s_tdata,
  input  logic [AXI_DATA_WIDTH/8-1:0]   s_axis_mm2s_tkeep,
  input  logic                          s_axis_mm2s_tlast,
  input  logic                          m_axis_mm2s_tready,
  output logic                          m_axis_mm2s_tvalid,
  output logic [AXI_DATA_WIDTH-1:0]     m_axis_mm2s_tdata,
  output logic [AXI_DATA_WIDTH/8-1:0]   m_axis_mm2s_tkeep,
  output logic                          m_axis_mm2s_tlast,
  output logic [DEST_WIDTH-1:0]         m_axis_mm2s_tdest
);
  localparam int LB = $clog2(AXI_DATA_WIDTH / 8);
  mm2s_state_t state, state_n;
  mm2s_instr_t ins;
  logic [MM2S_INSTR_W-1:0] fifo_tdata;
  logic fifo_tvalid, pop, cmd_hs, tag_full, route_err, sts_dec;
  logic [DEST_WIDTH-1:0] cmd_dest;
  logic [22:0] cmd_beats;
  logic [7:0] outstanding, last_sts;
  logic err_sts, err_last, err_zero, unused_bits;
  assign unused_bits = ^scalar[31:1];
  assign ins         = mm2s_instr_t'(fifo_tdata);
  assign pop         = state == ST_IDLE && fifo_tvalid && outstanding < 8'(MAX_OUTSTANDING) && !tag_full;
  assign cmd_hs      = m_axis_mm2s_cmd_tvalid & m_axis_mm2s_cmd_tready;
  assign sts_dec     = s_axis_mm2s_sts_tvalid && outstanding != 8'd0;
  assign s_axis_mm2s_sts_tready = 1'b1;

  fifo_axis #(.WIDTH(MM2S_INSTR_W), .DEPTH(INSTR_FIFO_DEPTH)) u_instr_fifo (
    .clk(clk), .rst_n(~rst),
    .s_tready(s_axis_mm2s_instr_tready), .s_tvalid(s_axis_mm2s_instr_tvalid), .s_tdata(s_axis_mm2s_instr_tdata),
    .m_tready(pop), .m_tvalid(fifo_tvalid), .m_tdata(fifo_tdata)
  );

  mm2s_mc_route #(.DATA_W(AXI_DATA_WIDTH), .DEST_W(DEST_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_route (
    .clk(clk), .rst(rst), .push(cmd_hs), .push_dest(cmd_dest), .push_beats(cmd_beats), .full(tag_full),
    .s_tready(s_axis_mm2s_tready), .s_tvalid(s_axis_mm2s_tvalid), .s_tdata(s_axis_mm2s_tdata),
    .s_tkeep(s_axis_mm2s_tkeep), .s_tlast(s_axis_mm2s_tlast),
    .m_tready(m_axis_mm2s_tready), .m_tvalid(m_axis_mm2s_tvalid), .m_tdata(m_axis_mm2s_tdata),
    .m_tkeep(m_axis_mm2s_tkeep), .m_tlast(m_axis_mm2s_tlast), .m_tdest(m_axis_mm2s_tdest), .err_last(route_err)
  );

  // issue state register
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_n;

  // zero-length instructions are popped but never leave IDLE
  always_comb begin
    state_n = state;
    state_n = state == ST_IDLE ? ((pop && ins.btt != '0) ? ST_ISSUE : ST_IDLE)
                               : (cmd_hs ? ST_IDLE : ST_ISSUE);
    m_axis_mm2s_cmd_tvalid = state == ST_ISSUE;
  end

  // command and its routing entry are captured at pop and held through ISSUE
  always_ff @(posedge clk) begin
    if (pop) begin
      m_axis_mm2s_cmd_tdata <= {4'd0, ins.tag, AXI_ADDR_WIDTH'(ins.addr),
                                32'(ins.btt) | (32'd1 << CMD_TYPE_BIT) | (32'd1 << CMD_EOF_BIT)};
      cmd_dest  <= DEST_WIDTH'(ins.dest);
      cmd_beats <= 23'((24'(ins.btt) + 24'((1 << LB) - 1)) >> LB);
    end
  end

  // credit counter, last status byte and sticky errors; a clear beats a same-cycle set
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      last_sts    <= '0;
      err_sts     <= 1'b0;
      err_last    <= 1'b0;
      err_zero    <= 1'b0;
    end else begin
      outstanding <= outstanding + 8'(cmd_hs) - 8'(sts_dec);
      if (s_axis_mm2s_sts_tvalid) last_sts <= s_axis_mm2s_sts_tdata;
      err_sts  <= ~scalar[0] & (err_sts | (s_axis_mm2s_sts_tvalid &
                  (outstanding == 8'd0 | ~s_axis_mm2s_sts_tdata[STS_OKAY_BIT])));
      err_last <= ~scalar[0] & (err_last | route_err);
      err_zero <= ~scalar[0] & (err_zero | (pop & (ins.btt == '0)));
    end
  end

`ifdef MM2S_PERF_CNT_EN
  logic [23:0] cmd_cnt;
  logic [15:0] pop_cnt, sts_cnt;
  // free-running wrapping activity counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_cnt <= '0;
      pop_cnt <= '0;
      sts_cnt <= '0;
    end else begin
      cmd_cnt <= cmd_cnt + 24'(cmd_hs);
      pop_cnt <= pop_cnt + 16'(pop);
      sts_cnt <= sts_cnt + 16'(s_axis_mm2s_sts_tvalid);
    end
  end
  assign status[0] = {cmd_cnt, last_sts};
  assign status[1] = {sts_cnt, pop_cnt};
`else
  assign status[0] = {24'd0, last_sts};
  assign status[1] = 32'd0;
`endif

  // error and credit status word
  always_comb begin
    status[2]               = '0;
    status[2][7:0]          = outstanding;
    status[2][ST2_ERR_STS]  = err_sts;
    status[2][ST2_ERR_LAST] = err_last;
    status[2][ST2_ERR_ZERO] = err_zero;
  end
endmodule

// File: tb/tb_mm2s_mc_ctrl.sv
// tb_mm2s_mc_ctrl: randomized self-checking bench with a transaction-level reference model
module tb_mm2s_mc_ctrl;
  import mm2s_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] scalar;
  logic [2:0][31:0] status;
  logic instr_tready, instr_tvalid;
  logic [MM2S_INSTR_W-1:0] instr_tdata;
  logic cmd_tready, cmd_tvalid;
  logic [71:0] cmd_tdata;
  logic sts_tready, sts_tvalid;
  logic [7:0] sts_tdata;
  logic s_tready, s_tvalid, s_tlast, m_tready, m_tvalid, m_tlast;
  logic [127:0] s_tdata, m_tdata;
  logic [15:0] s_tkeep, m_tkeep;
  logic [1:0] m_tdest;

  mm2s_mc_ctrl dut (
    .clk(clk), .rst(rst), .scalar(scalar), .status(status),
    .s_axis_mm2s_instr_tready(instr_tready), .s_axis_mm2s_instr_tvalid(instr_tvalid), .s_axis_mm2s_instr_tdata(instr_tdata),
    .m_axis_mm2s_cmd_tready(cmd_tready), .m_axis_mm2s_cmd_tvalid(cmd_tvalid), .m_axis_mm2s_cmd_tdata(cmd_tdata),
    .s_axis_mm2s_sts_tready(sts_tready), .s_axis_mm2s_sts_tvalid(sts_tvalid), .s_axis_mm2s_sts_tdata(sts_tdata),
    .s_axis_mm2s_tready(s_tready), .s_axis_mm2s_tvalid(s_tvalid), .s_axis_mm2s_tdata(s_tdata),
    .s_axis_mm2s_tkeep(s_tkeep), .s_axis_mm2s_tlast(s_tlast),
    .m_axis_mm2s_tready(m_tready), .m_axis_mm2s_tvalid(m_tvalid), .m_axis_mm2s_tdata(m_tdata),
    .m_axis_mm2s_tkeep(m_tkeep), .m_axis_mm2s_tlast(m_tlast), .m_axis_mm2s_tdest(m_tdest)
  );

  int checks = 0, passed = 0;
  int m_cmds = 0, m_pops = 0, m_sts = 0, m_out = 0, cmd_seen = 0;
  logic [7:0] m_last = '0;
  bit es = 0, el = 0, ez = 0, rnd_cmd = 0;
  logic [71:0] exp_q[$], obs_q[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic [71:0] exp_cmd(input logic [31:0] a, input int b, input logic [3:0] t);
    return (72'(t) << 64) | (72'(a) << 32) | (72'(1) << 30) | (72'(1) << 23) | 72'(b);
  endfunction

  always @(negedge clk) cmd_tready = rnd_cmd ? ($urandom_range(0, 2) != 0) : 1'b1;

  always begin
    @(negedge clk);
    #2;
    if (!rst && cmd_tvalid && cmd_tready) begin
      obs_q.push_back(cmd_tdata);
      cmd_seen++;
    end
  end

  task automatic send_instr(input logic [31:0] a, input int b, input logic [1:0] d, input logic [3:0] t);
    int n = 0;
    @(negedge clk);
    instr_tvalid = 1'b1;
    instr_tdata = {t, d, 23'(b), a};
    #1;
    while (!instr_tready && n < 50) begin @(negedge clk); #1; n++; end
    if (n >= 50) check("instr_accept_timeout", 0, 1);
    @(posedge clk); #1;
    instr_tvalid = 1'b0;
    m_pops++;
    if (b == 0) ez = 1;
    else begin
      m_cmds++;
      m_out++;
      exp_q.push_back(exp_cmd(a, b, t));
    end
  endtask

  task automatic wait_cmd(input int target);
    int n = 0;
    while (cmd_seen < target && n < 200) begin @(negedge clk); #3; n++; end
    if (cmd_seen < target) check("cmd_timeout", 128'(cmd_seen), 128'(target));
  endtask

  task automatic compare_cmds();
    while (obs_q.size() > 0 && exp_q.size() > 0) check("cmd", obs_q.pop_front(), exp_q.pop_front());
  endtask

  task automatic send_beat(input logic [127:0] dat, input logic lst, input logic [1:0] xd, input logic xl, input bit rnd);
    int n = 0;
    bit done = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata = dat;
      s_tkeep = '1;
      s_tlast = lst;
      m_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (m_tvalid && m_tready) begin
        check("beat_data", m_tdata, dat);
        check("beat_dest", m_tdest, xd);
        check("beat_last", m_tlast, xl);
        done = 1;
      end
      n++;
    end
    if (!done) check("beat_timeout", 0, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_beats(input int beats, input logic [1:0] d, input int bad_idx, input bit rnd);
    for (int i = 0; i < beats; i++)
      send_beat({$urandom, $urandom, $urandom, $urandom}, bad_idx >= 0 ? (i == bad_idx) : (i == beats - 1),
                d, i == beats - 1, rnd);
    if (bad_idx >= 0 && bad_idx != beats - 1) el = 1;
  endtask

  task automatic send_sts(input logic [7:0] b);
    @(negedge clk);
    sts_tvalid = 1'b1;
    sts_tdata = b;
    @(posedge clk); #1;
    sts_tvalid = 1'b0;
    m_sts++;
    m_last = b;
    if (m_out == 0 || !b[7]) es = 1;
    if (m_out > 0) m_out--;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    scalar = 32'd1;
    @(posedge clk); #1;
    scalar = 32'd0;
    es = 0; el = 0; ez = 0;
  endtask

  task automatic check_status(input string tag);
    logic [31:0] e2;
    @(negedge clk); #1;
    e2 = 32'(m_out & 255);
    e2[10] = ez;
    e2[9] = el;
    e2[8] = es;
    check({tag, "_st0_sts"}, status[0][7:0], m_last);
`ifdef MM2S_PERF_CNT_EN
    check({tag, "_st0_cmds"}, status[0][31:8], m_cmds[23:0]);
    check({tag, "_st1"}, status[1], {m_sts[15:0], m_pops[15:0]});
`else
    check({tag, "_st0_cmds"}, status[0][31:8], 0);
    check({tag, "_st1"}, status[1], 0);
`endif
    check({tag, "_st2"}, status[2], e2);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [71:0] c;
    int n, base;
    scalar = 0; instr_tvalid = 0; instr_tdata = '0; sts_tvalid = 0; sts_tdata = '0;
    s_tvalid = 1; s_tdata = '0; s_tkeep = '0; s_tlast = 0; m_tready = 1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_cmd_tvalid", cmd_tvalid, 0);
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_instr_tready", instr_tready, 0);
    check("rst_sts_tready", sts_tready, 1);
    check("rst_status", 128'(status), 0);
    s_tvalid = 0;
    @(negedge clk);
    rst = 0;

    send_instr(32'h1000, 64, 2'd2, 4'd5);
    wait_cmd(m_cmds);
    c = obs_q.size() > 0 ? obs_q[0] : '0;
    check("basic_cmd_btt", c[22:0], 64);
    check("basic_cmd_eof", c[30], 1);
    check("basic_cmd_addr", c[63:32], 32'h1000);
    compare_cmds();
    send_beats(4, 2'd2, -1, 0);
    send_sts(8'h85);
    check_status("basic");

    send_instr(32'h2000, 70, 2'd1, 4'd3);
    wait_cmd(m_cmds);
    compare_cmds();
    send_beats(5, 2'd1, -1, 0);
    send_sts(8'h83);
    check_status("btt70");

    send_instr(32'h2400, 64, 2'd3, 4'd1);
    wait_cmd(m_cmds);
    compare_cmds();
    send_beats(4, 2'd3, 1, 0);
    send_sts(8'h81);
    check_status("errlast");

    send_instr(32'h2800, 16, 2'd0, 4'd2);
    wait_cmd(m_cmds);
    compare_cmds();
    send_beats(1, 2'd0, -1, 0);
    send_sts(8'h40);
    check_status("slverr");
    clear_errs();
    check_status("clear");

    send_instr(32'h3000, 0, 2'd1, 4'd2);
    repeat (6) @(negedge clk);
    #3;
    check("zero_nocmd", 128'(cmd_seen), 128'(m_cmds));
    check_status("zero");

    send_sts(8'h80);
    check_status("underflow");

    @(negedge clk);
    scalar = 32'd1;
    sts_tvalid = 1'b1;
    sts_tdata = 8'h00;
    @(posedge clk); #1;
    scalar = 32'd0;
    sts_tvalid = 1'b0;
    m_sts++; m_last = 8'h00; es = 0; el = 0; ez = 0;
    check_status("clear_wins");

    rnd_cmd = 1;
    for (int k = 0; k < 16; k++) begin
      logic [31:0] a;
      int b;
      logic [1:0] d;
      logic [3:0] t;
      a = $urandom;
      b = $urandom_range(1, 300);
      d = 2'($urandom_range(0, 3));
      t = 4'($urandom_range(0, 15));
      send_instr(a, b, d, t);
      wait_cmd(m_cmds);
      compare_cmds();
      send_beats((b + 15) / 16, d, -1, 1);
      send_sts(8'h80 | 8'(t));
      check_status("rnd");
    end
    rnd_cmd = 0;
    m_tready = 1;

    base = cmd_seen;
    for (int i = 0; i < 12; i++) send_instr(32'h4000 + 32'(i * 16), 16, 2'(i % 4), 4'(i));
    repeat (30) @(negedge clk);
    #3;
    check("limit_cmds", 128'(cmd_seen - base), 8);
    check("limit_out", status[2][7:0], 8);
    for (int i = 0; i < 8; i++) send_beats(1, 2'(i % 4), -1, 0);
    repeat (5) @(negedge clk);
    #3;
    check("limit_hold", 128'(cmd_seen - base), 8);
    send_sts(8'h80);
    n = 0;
    do begin @(negedge clk); #1; n++; end while (!cmd_tvalid && n < 5);
    check("ninth_issue", 128'(n), 2);
    for (int k = 8; k < 12; k++) begin
      wait_cmd(base + k + 1);
      send_beats(1, 2'(k % 4), -1, 0);
      if (k < 11) send_sts(8'h80);
    end
    repeat (8) send_sts(8'h80);
    compare_cmds();
    check_status("limit_end");
    check("cmd_leftover", 128'(obs_q.size() + exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mm2s_mc_ctrl.md
# mm2s_mc_ctrl

Multi-destination, credit-limited successor to the single-queue MM2S controller. It sits between the core instruction dispatcher and the DataMover MM2S channel. It converts memory sub-instructions into DataMover commands and keeps the number of in-flight commands within a parameter limit. It routes the returning read data to one of `NUM_DEST` consumers, regenerating `tlast` from the byte count and checking it against the upstream `tlast`.

## Interface
- `AXI_ADDR_WIDTH`, 32: DataMover address width.
- `AXI_DATA_WIDTH`, 128: data stream width (power of two, ≥ 32).
- `NUM_DEST`, 4: number of data consumers; `DEST_WIDTH = $clog2(NUM_DEST)`, minimum 1.
- `INSTR_FIFO_DEPTH`, 128: instruction queue depth.
- `MAX_OUTSTANDING`, 8: commands issued but not yet status-acknowledged (power of two, ≤ 255).
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous, active-high.
- `scalar` in 32: bit 0 set clears the sticky error bits; other bits are reserved.
- `status` out 3×32: counters and errors (see Operation).
- `s_axis_mm2s_instr_{tready,tvalid,tdata}`: instruction stream, `tdata` is `MM2S_INSTR_W` bits.
- `m_axis_mm2s_cmd_{tready,tvalid,tdata}`: DataMover command, `tdata` is `AXI_ADDR_WIDTH+40` bits.
- `s_axis_mm2s_sts_{tready,tvalid,tdata[7:0]}`: DataMover status.
- `s_axis_mm2s_{tready,tvalid,tdata,tkeep,tlast}`: read data from the DataMover.
- `m_axis_mm2s_{tready,tvalid,tdata,tkeep,tlast,tdest[DEST_WIDTH-1:0]}`: routed data.

## Operation
- Instruction fields, LSB first: `addr[AXI_ADDR_WIDTH]`, `btt[23]`, `dest[DEST_WIDTH]`, `tag[4]`.
- Instructions enter a FIFO of depth `INSTR_FIFO_DEPTH`.
- Command issue FSM:
  - IDLE: pop the FIFO head when `outstanding < MAX_OUTSTANDING` and the tag queue is not full, then go to ISSUE.
  - ISSUE: hold `cmd_tvalid` until handshake, then return to IDLE.
- Command layout:
  - `[22:0]` btt; `[23]` = 1 (INCR); `[29:24]` = 0; `[30]` EOF = 1; `[31]` = 0.
  - Address starts at bit 32, followed by `tag[3:0]` and 4 reserved zero bits.
- An instruction with `btt == 0` is consumed without issuing a command and sets sticky `err_zero`.
- On command handshake, the entry {`dest`, `beats`} is pushed into a tag queue of depth `MAX_OUTSTANDING`.
  - `beats = (btt + BYTES-1) >> log2(BYTES)`, where `BYTES = AXI_DATA_WIDTH/8`.
- `outstanding` counter (8 bits):
  - Increments on command handshake and decrements on status handshake.
  - A simultaneous increment and decrement leaves it unchanged.
  - It never underflows; a status arriving while `outstanding == 0` sets sticky `err_sts`.
- Status stream:
  - `sts_tready` is constantly 1.
  - Sticky `err_sts` is also set when `sts_tdata[7]` (OKAY) is 0.
- Router:
  - Data passes through only while the tag queue is non-empty; otherwise `s_axis_mm2s_tready` is 0.
  - `m_tdest` is taken from the queue head.
  - A beat counter counts up to `beats`; `m_tlast` is asserted on the counted final beat and the queue pops on that handshake.
  - If upstream `tlast` differs from the counted last, sticky `err_last` is set. The output `tlast` always follows the count.
- `status` words:
  - `status[0]`: `[31:8]` command count, `[7:0]` last status byte.
  - `status[1]`: `[15:0]` instructions popped, `[31:16]` status count.
  - `status[2]`: `[7:0]` `outstanding`, `[8]` `err_sts`, `[9]` `err_last`, `[10]` `err_zero`, other bits 0.
- All counters wrap. A clear through `scalar[0]` wins over a simultaneous error set.

## Timing
- Reset:
  - All FIFOs and queues are flushed; FSM goes to IDLE; counters and errors are 0.
  - `cmd_tvalid`, `m_tvalid`, `s_axis_mm2s_tready` and `s_instr_tready` are 0; `sts_tready` is 1.
  - A reset during operation abandons in-flight transfers; no recovery is attempted.
- The command is registered: `cmd_tvalid` rises 1 cycle after the instruction-FIFO pop. Throughput is 1 command per 2 cycles.
- The data path is combinational (0 latency): `s_tready = m_tready & tag_nonempty`, `m_tvalid = s_tvalid & tag_nonempty`.
- A tag pushed in cycle N is usable by the router in cycle N+1.
- Status, counter and error updates appear 1 cycle after the triggering handshake.

## Configuration
- `MM2S_PERF_CNT_EN` defined: the counters in `status[0][31:8]` and all of `status[1]` are implemented.
- Not defined: those fields are tied to 0 and their registers are removed.
- `status[0][7:0]` and `status[2]` are always present.

## Structure
- Package `mm2s_pkg`:
  - `mm2s_instr_t` packed struct and `MM2S_INSTR_W`.
  - Command bit-position constants.
  - Status byte field constants (OKAY = bit 7, tag = bits 3:0).
  - `status[2]` bit indices.
- Existing `fifo_axis` is used for the instruction queue, with `rst_n = ~rst`.
- New sub-module `mm2s_mc_route` contains the tag queue, beat counter, tdest/tlast generation and the `err_last` check.

## Test plan
- Instruction addr 0x1000, btt 64, dest 2 (128-bit data): command `[22:0]`=64, `[30]`=1, address field 0x1000; 4 data beats out with `tdest`=2 and `tlast` on beat 4; `status[0][31:8]`=1.
- Instruction btt 70: `beats` = 5; `tlast` on beat 5.
- 12 instructions with status held off, `MAX_OUTSTANDING`=8: exactly 8 commands issue; after 1 status, the 9th issues the following cycle; `status[2][7:0]` reads 8.
- Status byte 0x40 (SLVERR): `status[2][8]`=1; `scalar[0]`=1 for one cycle clears it.
- Upstream `tlast` on beat 2 of 4: `err_last`=1 and output `tlast` still on beat 4. Instruction with btt 0: no command, `err_zero`=1.
- Build without `MM2S_PERF_CNT_EN`: `status[1]`=0 after traffic; `status[2]` still behaves as above.
